fdiv_sqrt_arbiter: RTL and testbench

FDIV_SQRT_ARBITER -- requirements
Module: fdiv_sqrt_arbiter

---
 rtl/fdiv_sqrt_pkg.sv | 15 +
 rtl/fdiv_sqrt_arbiter_rr_arb2.sv | 12 +
 rtl/fdiv_sqrt_arbiter.sv | 124 ++++++++++++
 tb/tb_fdiv_sqrt_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_sqrt_pkg.sv
// Shared types and widths for the div/sqrt arbiter slice.
// Holds the FSM state enum and the recoded-float field widths.
package fdiv_sqrt_pkg;

  localparam int RM_W   = 3;
  localparam int FLAG_W = 5;
  localparam int REC_W  = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fdiv_sqrt_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// ptr names the requester that wins when both are asserting.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~ptr | ~req[1]);
  assign gnt[1] = req[1] & ( ptr | ~req[0]);

endmodule

// File: rtl/fdiv_sqrt_arbiter.sv
// Shares one div/sqrt unit between two requesters.
// Single operation in flight; per-requester kill drops its result.
module fdiv_sqrt_arbiter
  import fdiv_sqrt_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_sqrt,
  input  logic [1:0][REC_W-1:0]       req_a,
  input  logic [1:0][REC_W-1:0]       req_b,
  input  logic [1:0][RM_W-1:0]        req_rm,
  input  logic [1:0][TAG_W-1:0]       req_tag,
  input  logic [1:0]                  kill,
  input  logic                        unit_in_ready,
  output logic                        unit_in_valid,
  output logic                        unit_sqrt,
  output logic [REC_W-1:0]            unit_a,
  output logic [REC_W-1:0]            unit_b,
  output logic [RM_W-1:0]             unit_rm,
  input  logic                        unit_out_valid_div,
  input  logic                        unit_out_valid_sqrt,
  input  logic [REC_W-1:0]            unit_out,
  input  logic [FLAG_W-1:0]           unit_exc,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_id,
  output logic [TAG_W-1:0]            resp_tag,
  output logic [REC_W-1:0]            resp_data,
  output logic [FLAG_W-1:0]           resp_exc,
  output logic                        busy
);

  state_t             state;
  logic               ptr;
  logic               id;
  logic               sqrt;
  logic               discard;
  logic [TAG_W-1:0]   tag;
  logic [REC_W-1:0]   data;
  logic [FLAG_W-1:0]  exc;

  logic [1:0] gnt;
  logic       idle;
  logic       sel;
  logic       accept;
  logic       pulse;
  logic       own_kill;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign idle      = (state == IDLE);
  assign sel       = gnt[1];
  assign req_ready = (idle & unit_in_ready) ? gnt : 2'b00;
  assign accept    = |req_ready;

  assign unit_in_valid = idle & (|req_valid);
  assign unit_sqrt     = unit_in_valid & req_sqrt[sel];
  assign unit_a        = unit_in_valid ? req_a[sel]  : '0;
  assign unit_b        = unit_in_valid ? req_b[sel]  : '0;
  assign unit_rm       = unit_in_valid ? req_rm[sel] : '0;

  // Only a pulse of the type we issued belongs to us.
  assign pulse    = sqrt ? unit_out_valid_sqrt : unit_out_valid_div;
  assign own_kill = kill[id];

  assign resp_valid = (state == RESP);
  assign resp_id    = resp_valid & id;
  assign resp_tag   = resp_valid ? tag  : '0;
  assign resp_data  = resp_valid ? data : '0;
  assign resp_exc   = resp_valid ? exc  : '0;
  assign busy       = ~idle;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      id      <= 1'b0;
      sqrt    <= 1'b0;
      discard <= 1'b0;
      tag     <= '0;
      data    <= '0;
      exc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            id      <= sel;
            tag     <= req_tag[sel];
            sqrt    <= req_sqrt[sel];
            discard <= 1'b0;
            ptr     <= ~sel;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (own_kill) discard <= 1'b1;
          if (pulse) begin
            if (discard | own_kill) begin
              state <= IDLE;
            end else begin
              data  <= unit_out;
              exc   <= unit_exc;
              state <= RESP;
            end
          end
        end
        RESP: begin
          // A kill drops the response even alongside resp_ready.
          if (own_kill | resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_sqrt_arbiter.sv
// Directed bench for fdiv_sqrt_arbiter.
// Inputs change on the falling edge; outputs are checked #1 later.
module tb_fdiv_sqrt_arbiter;

  localparam int TAG_W = 5;
  localparam logic [32:0] F2 = 33'h080800000;
  localparam logic [32:0] F1 = 33'h080000000;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_sqrt;
  logic [1:0][32:0]      req_a;
  logic [1:0][32:0]      req_b;
  logic [1:0][2:0]       req_rm;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [1:0]            kill;
  logic                  unit_in_ready;
  logic                  unit_in_valid;
  logic                  unit_sqrt;
  logic [32:0]           unit_a;
  logic [32:0]           unit_b;
  logic [2:0]            unit_rm;
  logic                  unit_out_valid_div;
  logic                  unit_out_valid_sqrt;
  logic [32:0]           unit_out;
  logic [4:0]            unit_exc;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [TAG_W-1:0]      resp_tag;
  logic [32:0]           resp_data;
  logic [4:0]            resp_exc;
  logic                  busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_hs = 0;

  always #5 clock = ~clock;

  fdiv_sqrt_arbiter #(.TAG_W(TAG_W)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_sqrt            (req_sqrt),
    .req_a               (req_a),
    .req_b               (req_b),
    .req_rm              (req_rm),
    .req_tag             (req_tag),
    .kill                (kill),
    .unit_in_ready       (unit_in_ready),
    .unit_in_valid       (unit_in_valid),
    .unit_sqrt           (unit_sqrt),
    .unit_a              (unit_a),
    .unit_b              (unit_b),
    .unit_rm             (unit_rm),
    .unit_out_valid_div  (unit_out_valid_div),
    .unit_out_valid_sqrt (unit_out_valid_sqrt),
    .unit_out            (unit_out),
    .unit_exc            (unit_exc),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_id             (resp_id),
    .resp_tag            (resp_tag),
    .resp_data           (resp_data),
    .resp_exc            (resp_exc),
    .busy                (busy)
  );

  // A delivery is a handshake the owner did not kill in the same cycle.
  always @(posedge clock)
    if (reset_n && resp_valid && resp_ready && !kill[resp_id])
      n_hs++;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; req_sqrt = '0; req_a = '0; req_b = '0;
    req_rm = '0; req_tag = '0; kill = '0;
    unit_in_ready = 1'b1;
    unit_out_valid_div = 1'b0; unit_out_valid_sqrt = 1'b0;
    unit_out = '0; unit_exc = '0; resp_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    tick();
    #1;
    n_chk++;
    if ({busy, resp_valid, req_ready, unit_in_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {busy, resp_valid, req_ready, unit_in_valid});
    end
    n_chk++;
    if ({resp_id, resp_tag, resp_data, resp_exc} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h want 0",
               {resp_id, resp_tag, resp_data, resp_exc});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_div();
    int h0;
    do_reset();
    req_valid = 2'b01; req_a[0] = F2; req_b[0] = F1;
    req_rm[0] = 3'd0; req_tag[0] = 5'd5;
    unit_in_ready = 1'b0;
    #1;
    n_chk++;
    if ({unit_in_valid, req_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL stall_ready: got %b want 100", {unit_in_valid, req_ready});
    end
    tick();
    unit_in_ready = 1'b1;
    #1;
    n_chk++;
    if ({req_ready, unit_sqrt, unit_a, unit_b} !== {2'b01, 1'b0, F2, F1}) begin
      n_fail++;
      $display("FAIL issue_fields: got %b %h %h", req_ready, unit_a, unit_b);
    end
    tick();
    req_valid = 2'b00;
    #1;
    n_chk++;
    if ({busy, unit_in_valid, unit_a} !== {1'b1, 1'b0, 33'h0}) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b %b %h want 1 0 0",
               busy, unit_in_valid, unit_a);
    end
    tick(); tick();
    unit_out_valid_sqrt = 1'b1; unit_out = 33'h1234;
    tick();
    unit_out_valid_sqrt = 1'b0;
    #1;
    n_chk++;
    if ({resp_valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL wrong_type_pulse: got %b want 01", {resp_valid, busy});
    end
    unit_out_valid_div = 1'b1; unit_out = F2; unit_exc = 5'd0;
    tick();
    unit_out_valid_div = 1'b0; unit_out = '0;
    #1;
    n_chk++;
    if ({resp_valid, resp_id, resp_tag, resp_data, resp_exc} !==
        {1'b1, 1'b0, 5'd5, F2, 5'd0}) begin
      n_fail++;
      $display("FAIL single_resp: got %b %b %h %h %h", resp_valid, resp_id,
               resp_tag, resp_data, resp_exc);
    end
    h0 = n_hs;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    n_chk++;
    if ({resp_valid, busy, n_hs} !== {1'b0, 1'b0, h0 + 1}) begin
      n_fail++;
      $display("FAIL single_done: got %b %b hs=%0d want 0 0 hs=%0d",
               resp_valid, busy, n_hs, h0 + 1);
    end
  endtask

  task automatic test_contention();
    int h0;
    logic [1:0] exp;
    do_reset();
    h0 = n_hs;
    req_valid = 2'b11; req_tag[0] = 5'd1; req_tag[1] = 5'd2;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      n_chk++;
      if (req_ready !== exp) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp);
      end
      tick();
      unit_out_valid_div = 1'b1; unit_out = 33'(i);
      tick();
      unit_out_valid_div = 1'b0;
      resp_ready = 1'b1;
      #1;
      n_chk++;
      if ({resp_valid, resp_id, resp_tag, resp_data, req_ready} !==
          {1'b1, exp[1], exp[1] ? 5'd2 : 5'd1, 33'(i), 2'b00}) begin
        n_fail++;
        $display("FAIL rr_resp%0d: got %b %b %h %h %b", i, resp_valid,
                 resp_id, resp_tag, resp_data, req_ready);
      end
      tick();
      resp_ready = 1'b0;
    end
    req_valid = 2'b00;
    n_chk++;
    if (n_hs !== h0 + 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want %0d", n_hs - h0, 4);
    end
  endtask

  task automatic test_backpressure();
    int h0;
    do_reset();
    req_valid = 2'b10; req_sqrt = 2'b10; req_a[1] = F2; req_tag[1] = 5'd7;
    tick();
    req_valid = 2'b00;
    tick();
    unit_out_valid_sqrt = 1'b1; unit_out = F1; unit_exc = 5'h01;
    tick();
    unit_out_valid_sqrt = 1'b0; unit_out = '0; unit_exc = '0;
    req_valid = 2'b01;
    h0 = n_hs;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_chk++;
      if ({resp_valid, resp_id, resp_tag, resp_data, resp_exc, req_ready} !==
          {1'b1, 1'b1, 5'd7, F1, 5'h01, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %b %b %h %h %h %b", i, resp_valid,
                 resp_id, resp_tag, resp_data, resp_exc, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    n_chk++;
    if ({resp_valid, req_ready, n_hs} !== {1'b0, 2'b01, h0 + 1}) begin
      n_fail++;
      $display("FAIL bp_release: got %b %b hs=%0d want 0 01 hs=%0d",
               resp_valid, req_ready, n_hs - h0, 1);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_kill_busy();
    int h0;
    do_reset();
    h0 = n_hs;
    req_valid = 2'b01; req_tag[0] = 5'd3;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    kill = 2'b01;
    tick();
    kill = 2'b00;
    #1;
    n_chk++;
    if ({busy, resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL kill_busy_hold: got %b want 10", {busy, resp_valid});
    end
    unit_out_valid_div = 1'b1; unit_out = F2;
    tick();
    unit_out_valid_div = 1'b0;
    #1;
    n_chk++;
    if ({busy, resp_valid, n_hs} !== {1'b0, 1'b0, h0}) begin
      n_fail++;
      $display("FAIL kill_busy_drop: got %b %b hs=%0d want 0 0 hs=0",
               busy, resp_valid, n_hs - h0);
    end
    req_valid = 2'b01;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL kill_busy_next: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
  endtask

  task automatic test_kill_resp();
    int h0;
    do_reset();
    kill = 2'b11;
    req_valid = 2'b10; req_sqrt = 2'b10; req_tag[1] = 5'd9;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_kill_ready: got %b want 10", req_ready);
    end
    tick();
    kill = 2'b00; req_valid = 2'b00;
    unit_out_valid_div = 1'b1;
    tick();
    unit_out_valid_div = 1'b0;
    unit_out_valid_sqrt = 1'b1; unit_out = F2;
    tick();
    unit_out_valid_sqrt = 1'b0;
    #1;
    n_chk++;
    if ({resp_valid, resp_id, resp_tag, resp_data} !==
        {1'b1, 1'b1, 5'd9, F2}) begin
      n_fail++;
      $display("FAIL sqrt_resp: got %b %b %h %h",
               resp_valid, resp_id, resp_tag, resp_data);
    end
    kill = 2'b01;
    tick();
    kill = 2'b00;
    #1;
    n_chk++;
    if ({resp_valid, resp_id} !== 2'b11) begin
      n_fail++;
      $display("FAIL foreign_kill: got %b want 11", {resp_valid, resp_id});
    end
    h0 = n_hs;
    kill = 2'b10; resp_ready = 1'b1;
    tick();
    kill = 2'b00; resp_ready = 1'b0;
    #1;
    n_chk++;
    if ({resp_valid, busy, n_hs} !== {1'b0, 1'b0, h0}) begin
      n_fail++;
      $display("FAIL kill_vs_hs: got %b %b hs=%0d want 0 0 hs=0",
               resp_valid, busy, n_hs - h0);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_idle: got %b want 0", busy);
    end
    unit_out_valid_div = 1'b1; unit_out = F2;
    tick();
    unit_out_valid_div = 1'b0;
    tick();
    #1;
    n_chk++;
    if ({resp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stale_pulse: got %b want 00", {resp_valid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single_div();
    test_contention();
    test_backpressure();
    test_kill_busy();
    test_kill_resp();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
